// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one imem request at a time, predicts the next PC
// statically and presents the fetched instruction to the F->D register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_i_fetch_stall,
   input  logic        ctrl_i_redirect,
   input  logic [31:0] ctrl_i_redirect_pc,
   output logic        imem_o_req,
   output logic [31:0] imem_o_addr,
   input  logic        imem_i_gnt,
   input  logic        imem_i_rvalid,
   input  logic [31:0] imem_i_rdata,
   output logic [31:0] fetch_o_instr,
   output logic [31:0] regF_o_pc,
   output logic [31:0] fetch_o_pre_pc,
   output logic        fetch_o_commit
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] cur_instr;
   logic [31:0] pred_pc;

   // Static predictor: JAL and backward branches taken, everything else pc+4.
   function automatic logic [31:0] predict(input logic [31:0] ins, input logic [31:0] pc);
      logic [31:0] imm_j, imm_b;
      imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      if (ins[6:0] == OP_JAL)
         return pc + imm_j;
      else if (ins[6:0] == OP_BRANCH && ins[31])
         return pc + imm_b;
      else
         return pc + 32'd4;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   // Output decode; a redirect suppresses both the request and the commit.
   always_comb begin
      imem_o_req     = 1'b0;
      fetch_o_commit = 1'b0;
      cur_instr      = NOP_INSTR;
      if (!rst && !ctrl_i_redirect) begin
         case (state_q)
            S_REQ:  imem_o_req = 1'b1;
            S_WAIT: if (imem_i_rvalid) begin
                       fetch_o_commit = 1'b1;
                       cur_instr      = imem_i_rdata;
                    end
            S_HOLD: begin
                       fetch_o_commit = 1'b1;
                       cur_instr      = hold_q;
                    end
            default: ;
         endcase
      end
   end

   assign imem_o_addr    = pc_q;
   assign pred_pc        = predict(cur_instr, pc_q);
   assign fetch_o_instr  = fetch_o_commit ? cur_instr : NOP_INSTR;
   assign regF_o_pc      = fetch_o_commit ? pc_q      : 32'd0;
   assign fetch_o_pre_pc = fetch_o_commit ? pred_pc   : 32'd0;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      if (ctrl_i_redirect) begin
         pc_d = ctrl_i_redirect_pc & ~32'd3;
         case (state_q)
            S_WAIT, S_DROP: state_d = imem_i_rvalid ? S_REQ : S_DROP;
            default:        state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ:  if (imem_i_gnt) state_d = S_WAIT;
            S_WAIT: if (imem_i_rvalid) begin
                       if (ctrl_i_fetch_stall) begin
                          hold_d  = imem_i_rdata;
                          state_d = S_HOLD;
                       end else begin
                          pc_d    = pred_pc;
                          state_d = S_REQ;
                       end
                    end
            S_HOLD: if (!ctrl_i_fetch_stall) begin
                       pc_d    = pred_pc;
                       state_d = S_REQ;
                    end
            S_DROP: if (imem_i_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end
   end

endmodule
